fp16_add_feeder: RTL and testbench

//  Upstream sequencer for the half-precision floating-point adder. Buffers FP16 operand pairs in a small FIFO,

---
 rtl/fp16_pkg.sv | 13 +
 rtl/fp16_pair_fifo.sv | 53 +++++
 rtl/fp16_add_feeder.sv | 131 +++++++++++++
 tb/tb_fp16_add_feeder.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared types and constants for the FP16 adder feeder.
package fp16_pkg;

  localparam int FP16_W = 16;
  localparam logic [FP16_W-1:0] FP16_QNAN = 16'h7E00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } feeder_state_t;

endpackage

// File: rtl/fp16_pair_fifo.sv
// Operand-pair FIFO for the FP16 adder feeder; entries are {a, b}.
module fp16_pair_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic                         pop,
  input  logic [W-1:0]                 wdata,
  output logic [W-1:0]                 rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // full is taken from the registered count, so a pop never frees a slot in the same cycle
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fp16_add_feeder.sv
// Sequencer feeding one FP16 add at a time to the adder and registering its result.
// Optional WAIT-state abort with qNaN result is enabled by defining FP_FEEDER_TIMEOUT_EN.
//
// state    | meaning
// ST_IDLE  | no op in flight; pops the FIFO head when the output register is free
// ST_ISSUE | fpa_add held high for ADD_HOLD cycles with operands stable
// ST_WAIT  | fpa_add low; first cycle ignores fpa_ready, then captures result on fpa_ready
module fp16_add_feeder
  import fp16_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int ADD_HOLD = 10,
  parameter int TIMEOUT  = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [FP16_W-1:0]            in_a,
  input  logic [FP16_W-1:0]            in_b,
  output logic                         fpa_add,
  output logic [FP16_W-1:0]            fpa_a,
  output logic [FP16_W-1:0]            fpa_b,
  input  logic [FP16_W-1:0]            fpa_result,
  input  logic                         fpa_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [FP16_W-1:0]            out_result,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   pending_count,
  output logic                         timeout_err
);

  localparam int HW = $clog2(ADD_HOLD+1);

  feeder_state_t       state;
  logic [HW-1:0]       hold_cnt;
  logic                guard;
  logic                fifo_full;
  logic                fifo_empty;
  logic                fifo_pop;
  logic [2*FP16_W-1:0] head;

  assign in_ready = ~fifo_full;
  assign busy     = (state != ST_IDLE);
  assign fifo_pop = (state == ST_IDLE) && !fifo_empty && !out_valid;

  fp16_pair_fifo #(
    .DEPTH (DEPTH),
    .W     (2*FP16_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_valid),
    .pop   (fifo_pop),
    .wdata ({in_a, in_b}),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (pending_count)
  );

`ifdef FP_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT+1);
  logic [TW-1:0] wait_cnt;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      fpa_add    <= 1'b0;
      fpa_a      <= '0;
      fpa_b      <= '0;
      hold_cnt   <= '0;
      guard      <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
`ifdef FP_FEEDER_TIMEOUT_EN
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) out_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            {fpa_a, fpa_b} <= head;
            fpa_add        <= 1'b1;
            hold_cnt       <= HW'(ADD_HOLD - 1);
            state          <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (hold_cnt == '0) begin
            fpa_add <= 1'b0;
            guard   <= 1'b1;
            state   <= ST_WAIT;
`ifdef FP_FEEDER_TIMEOUT_EN
            wait_cnt <= TW'(TIMEOUT - 1);
`endif
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        ST_WAIT: begin
          // guard cycle drops a ready left over from the previous (possibly aborted) op
          guard <= 1'b0;
          if (!guard && fpa_ready) begin
            out_result <= fpa_result;
            out_valid  <= 1'b1;
            state      <= ST_IDLE;
          end
`ifdef FP_FEEDER_TIMEOUT_EN
          else if (wait_cnt == '0) begin
            out_result  <= FP16_QNAN;
            out_valid   <= 1'b1;
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - TW'(1);
          end
`endif
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp16_add_feeder.sv
// Directed self-checking bench for fp16_add_feeder with a latency-programmable adder stub.
// The timeout scenario runs only when FP_FEEDER_TIMEOUT_EN is defined.
module tb_fp16_add_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        fpa_add;
  logic [15:0] fpa_a;
  logic [15:0] fpa_b;
  logic [15:0] fpa_result = '0;
  logic        fpa_ready = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_result;
  logic        busy;
  logic [2:0]  pending_count;
  logic        timeout_err;

  int passed = 0;
  int total  = 0;

  fp16_add_feeder dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_a          (in_a),
    .in_b          (in_b),
    .fpa_add       (fpa_add),
    .fpa_a         (fpa_a),
    .fpa_b         (fpa_b),
    .fpa_result    (fpa_result),
    .fpa_ready     (fpa_ready),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .busy          (busy),
    .pending_count (pending_count),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  // Stub adder: x+x doubles (exponent+1 for normal numbers), plus one hand-computed mixed pair.
  function automatic logic [15:0] stub_sum(input logic [15:0] a, input logic [15:0] b);
    if (a == b) return a + 16'h0400;
    if (a == 16'h3C00 && b == 16'h4000) return 16'h4200;
    return 16'h0000;
  endfunction

  int   lat = 5;
  bit   stub_never = 1'b0;
  logic prev_add = 1'b0;
  bit   counting = 1'b0;
  int   lat_cnt = 0;

  always @(posedge clk) begin
    prev_add <= fpa_add;
    if (fpa_add && !prev_add) begin
      fpa_ready <= 1'b0;
      counting  <= 1'b0;
    end else if (!fpa_add && prev_add) begin
      counting <= 1'b1;
      lat_cnt  <= 1;
    end else if (counting) begin
      if (lat_cnt >= lat) begin
        counting <= 1'b0;
        if (!stub_never) begin
          fpa_ready  <= 1'b1;
          fpa_result <= stub_sum(fpa_a, fpa_b);
        end
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end
  end

  int          add_cycles = 0;
  int          add_rises = 0;
  logic        mon_prev_add = 1'b0;
  logic [15:0] beats[$];

  always @(posedge clk) begin
    mon_prev_add <= fpa_add;
    if (fpa_add) add_cycles++;
    if (fpa_add && !mon_prev_add) add_rises++;
    if (out_valid && out_ready) beats.push_back(out_result);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, observed no end, expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic push_one(input logic [15:0] a, input logic [15:0] b, output bit acc);
    @(negedge clk);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    acc      = in_ready;
  endtask

  task automatic push_single(input logic [15:0] a, input logic [15:0] b);
    bit acc;
    push_one(a, b, acc);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_beats(input int n, input int maxc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (beats.size() >= n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  logic [15:0] fill_a [6];
  logic [15:0] fill_x [5];
  bit          ok;
  bit          acc;
  bit          stable;
  int          n_acc;
  int          rises0;

  initial begin
    fill_a = '{16'h3C00, 16'h4000, 16'h4200, 16'h4500, 16'h3800, 16'h4B10};
    fill_x = '{16'h4000, 16'h4400, 16'h4600, 16'h4900, 16'h3C00};

    // Reset
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_fpa_add", fpa_add, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending_count, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
`ifndef FP_FEEDER_TIMEOUT_EN
    chk("timeout_err_tied", timeout_err, 0);
`endif

    // Single op
    add_cycles = 0;
    add_rises  = 0;
    push_single(16'h4B10, 16'h4B10);
    wait_out(100, ok);
    chk("single_wait", ok, 1);
    chk("single_result", out_result, 16'h4F10);
    chk("single_add_cycles", add_cycles, 10);
    chk("single_add_rises", add_rises, 1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
    chk("single_cleared", out_valid, 0);
    chk("single_beats", beats.size(), 1);

    // Fill: one pops into flight, four queue, sixth is refused
    beats.delete();
    n_acc = 0;
    for (int i = 0; i < 6; i++) begin
      push_one(fill_a[i], fill_a[i], acc);
      if (acc) n_acc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (40) @(negedge clk);
    chk("fill_accepted", n_acc, 5);
    chk("fill_in_ready", in_ready, 0);
    chk("fill_pending", pending_count, 4);
    chk("fill_out_valid", out_valid, 1);
    chk("fill_busy", busy, 0);
    out_ready = 1'b1;
    wait_beats(5, 600, ok);
    chk("fill_drain_wait", ok, 1);
    for (int i = 0; i < 5; i++) begin
      if (i < beats.size()) chk($sformatf("fill_order_%0d", i), beats[i], fill_x[i]);
    end
    repeat (2) @(negedge clk);
    chk("fill_in_ready_after", in_ready, 1);
    chk("fill_pending_after", pending_count, 0);

    // Backpressure
    out_ready = 1'b0;
    beats.delete();
    push_single(16'hCCEC, 16'hCCEC);
    wait_out(100, ok);
    chk("bp_wait", ok, 1);
    rises0 = add_rises;
    push_single(16'h3C00, 16'h4000);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!out_valid || out_result !== 16'hD0EC) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_no_new_add", add_rises, rises0);
    chk("bp_pending", pending_count, 1);
    out_ready = 1'b1;
    wait_beats(2, 200, ok);
    chk("bp_drain_wait", ok, 1);
    if (beats.size() >= 2) begin
      chk("bp_beat0", beats[0], 16'hD0EC);
      chk("bp_beat1", beats[1], 16'h4200);
    end

`ifdef FP_FEEDER_TIMEOUT_EN
    // Timeout
    out_ready  = 1'b0;
    stub_never = 1'b1;
    beats.delete();
    push_single(16'h4B10, 16'h4B10);
    wait_out(400, ok);
    chk("to_wait", ok, 1);
    chk("to_result", out_result, 16'h7E00);
    chk("to_err", timeout_err, 1);
    stub_never = 1'b0;
    out_ready  = 1'b1;
    push_single(16'h3C00, 16'h3C00);
    wait_beats(2, 200, ok);
    chk("to_next_wait", ok, 1);
    if (beats.size() >= 2) chk("to_next_result", beats[1], 16'h4000);
    chk("to_err_sticky", timeout_err, 1);
`endif

    // Async reset mid-WAIT with three queued
    out_ready = 1'b1;
    lat = 100;
    for (int i = 0; i < 4; i++) push_one(16'h4200, 16'h4200, acc);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (20) @(negedge clk);
    chk("ar_pending_before", pending_count, 3);
    chk("ar_busy_before", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_fpa_add", fpa_add, 0);
    chk("ar_out_valid", out_valid, 0);
    chk("ar_pending", pending_count, 0);
    chk("ar_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar_in_ready", in_ready, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
